// File: rtl/alu_ctrl_seq.sv
// Hardwired fetch/execute control sequencer for the DataPath's register-register ALU instructions.
// Optional macro CTRL_SEQ_MEM_WAIT_EN holds T1 until mem_rdy is sampled high.
module alu_ctrl_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    run,
  input  logic                    mem_rdy,
  input  logic [DATA_WIDTH-1:0]   ir,
  output logic                    PCout,
  output logic                    IncPC,
  output logic                    MARin,
  output logic                    Zin,
  output logic                    Zlo_out,
  output logic                    Zhi_out,
  output logic                    PCin,
  output logic                    Read,
  output logic                    MDRin,
  output logic                    MDRout,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    HIin,
  output logic                    LOin,
  output logic [REG_COUNT-1:0]    r_out,
  output logic [REG_COUNT-1:0]    r_in,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  output logic [DATA_WIDTH-1:0]   instr_count
);

  localparam int RA_MSB = DATA_WIDTH - OPCODE_WIDTH - 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_BIN_MAX = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL     = OPCODE_WIDTH'(15);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV     = OPCODE_WIDTH'(16);
  localparam logic [OPCODE_WIDTH-1:0] OP_NEG     = OPCODE_WIDTH'(17);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT     = OPCODE_WIDTH'(18);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_BIN_T4, S_BIN_T5,
    S_UN_T4,
    S_MD_T4, S_MD_T5, S_MD_T6
  } state_t;

  typedef enum logic [1:0] {CLS_BIN, CLS_UN, CLS_MULDIV, CLS_ILL} cls_t;

  state_t                  r_state;
  state_t                  w_next_state;
  cls_t                    w_cls;
  logic [DATA_WIDTH-1:0]   r_count;
  logic [OPCODE_WIDTH-1:0] w_op;
  logic [3:0]              w_ra;
  logic [3:0]              w_rb;
  logic [3:0]              w_rc;
  logic                    w_ra_ok;
  logic                    w_rb_ok;
  logic                    w_rc_ok;
  logic                    w_unused;

  assign w_op     = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_ra     = ir[RA_MSB -: 4];
  assign w_rb     = ir[RA_MSB-4 -: 4];
  assign w_rc     = ir[RA_MSB-8 -: 4];
  assign w_unused = ^{mem_rdy, ir[RA_MSB-12:0]};

  // A 4-bit select field can name registers beyond REG_COUNT; those make the instruction illegal.
  assign w_ra_ok = int'(w_ra) < REG_COUNT;
  assign w_rb_ok = int'(w_rb) < REG_COUNT;
  assign w_rc_ok = int'(w_rc) < REG_COUNT;

  function automatic logic [REG_COUNT-1:0] onehot(input logic [3:0] sel);
    return REG_COUNT'(1) << sel;
  endfunction

  always_comb begin
    w_cls = CLS_ILL;
    if (w_op <= OP_BIN_MAX)
      w_cls = (w_ra_ok && w_rb_ok && w_rc_ok) ? CLS_BIN : CLS_ILL;
    else if (w_op == OP_MUL || w_op == OP_DIV)
      w_cls = (w_ra_ok && w_rb_ok) ? CLS_MULDIV : CLS_ILL;
    else if (w_op == OP_NEG || w_op == OP_NOT)
      w_cls = (w_ra_ok && w_rb_ok) ? CLS_UN : CLS_ILL;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clear) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (done) r_count <= r_count + DATA_WIDTH'(1);
    end
  end

  assign instr_count = r_count;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = r_state;
    PCout   = 1'b0;  IncPC  = 1'b0;  MARin  = 1'b0;  Zin   = 1'b0;
    Zlo_out = 1'b0;  Zhi_out = 1'b0; PCin   = 1'b0;  Read  = 1'b0;
    MDRin   = 1'b0;  MDRout = 1'b0;  IRin   = 1'b0;  Yin   = 1'b0;
    HIin    = 1'b0;  LOin   = 1'b0;
    r_out   = '0;
    r_in    = '0;
    alu_op  = '0;
    done    = 1'b0;
    illegal = 1'b0;

    unique case (r_state)
      S_IDLE: if (run) w_next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        w_next_state = S_T1;
      end
      S_T1: begin
        Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
`ifdef CTRL_SEQ_MEM_WAIT_EN
        w_next_state = mem_rdy ? S_T2 : S_T1;
`else
        w_next_state = S_T2;
`endif
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next_state = S_T3;
      end
      S_T3: begin
        unique case (w_cls)
          CLS_BIN: begin
            r_out = onehot(w_rb); Yin = 1'b1;
            w_next_state = S_BIN_T4;
          end
          CLS_UN: begin
            r_out = onehot(w_rb); alu_op = w_op; Zin = 1'b1;
            w_next_state = S_UN_T4;
          end
          CLS_MULDIV: begin
            r_out = onehot(w_ra); Yin = 1'b1;
            w_next_state = S_MD_T4;
          end
          default: begin
            illegal      = 1'b1;
            w_next_state = S_IDLE;
          end
        endcase
      end
      S_BIN_T4: begin
        r_out = onehot(w_rc); alu_op = w_op; Zin = 1'b1;
        w_next_state = S_BIN_T5;
      end
      S_BIN_T5, S_UN_T4: begin
        Zlo_out = 1'b1; r_in = onehot(w_ra); done = 1'b1;
        w_next_state = run ? S_T0 : S_IDLE;
      end
      S_MD_T4: begin
        r_out = onehot(w_rb); alu_op = w_op; Zin = 1'b1;
        w_next_state = S_MD_T5;
      end
      S_MD_T5: begin
        Zlo_out = 1'b1; LOin = 1'b1;
        w_next_state = S_MD_T6;
      end
      S_MD_T6: begin
        Zhi_out = 1'b1; HIin = 1'b1; done = 1'b1;
        w_next_state = run ? S_T0 : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
